// File: rtl/cla_seq_pkg.sv
// Shared types and constants for the sequential carry-lookahead adder.
package cla_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIB_W = 4;

  function automatic int calc_nib(input int width);
    return width / NIB_W;
  endfunction

endpackage

// File: rtl/cla4_slice.sv
// Combinational 4-bit carry-lookahead nibble adder.
module cla4_slice (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  assign p = x ^ y;
  assign g = x & y;

  // Every carry is expanded directly from generate/propagate terms.
  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & ci);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);

  assign s  = p ^ c[3:0];
  assign co = c[4];

endmodule

// File: rtl/cla_seq_adder.sv
// Wide adder that reuses one cla4_slice over WIDTH/4 cycles, LS nibble first.
// Optional subtract port enabled by defining CLA_SEQ_SUB_EN.
module cla_seq_adder
  import cla_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CLA_SEQ_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; in_ready is only high in IDLE, out_valid only in DONE.

  localparam int NIB   = calc_nib(WIDTH);
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry;
  logic [IDX_W-1:0] idx;

  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic             accept;
  logic             last;
  logic [3:0]       nib_a;
  logic [3:0]       nib_b;
  logic [3:0]       nib_s;
  logic             nib_c;

`ifdef CLA_SEQ_SUB_EN
  // Two's-complement subtract: invert B and force the carry-in to 1.
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub ? 1'b1 : cin;
`else
  assign b_eff   = b;
  assign cin_eff = cin;
`endif

  assign accept    = in_valid && (state == IDLE);
  assign last      = (idx == IDX_W'(NIB - 1));
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_comb begin
    nib_a = 4'h0;
    nib_b = 4'h0;
    for (int n = 0; n < NIB; n++) begin
      if (idx == IDX_W'(n)) begin
        nib_a = op_a[n*NIB_W +: NIB_W];
        nib_b = op_b[n*NIB_W +: NIB_W];
      end
    end
  end

  cla4_slice u_slice (
    .x  (nib_a),
    .y  (nib_b),
    .ci (carry),
    .s  (nib_s),
    .co (nib_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      op_a  <= '0;
      op_b  <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_a  <= a;
            op_b  <= b_eff;
            carry <= cin_eff;
            idx   <= '0;
            sum   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          for (int n = 0; n < NIB; n++) begin
            if (idx == IDX_W'(n)) sum[n*NIB_W +: NIB_W] <= nib_s;
          end
          carry <= nib_c;
          if (last) begin
            cout  <= nib_c;
            idx   <= '0;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_seq_adder.sv
// Scoreboard bench for cla_seq_adder (WIDTH=16), directed hand-computed vectors.
module tb_cla_seq_adder;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  logic [W:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  cla_seq_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef CLA_SEQ_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: pops the expected result when the DUT hands one over.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", {15'd0, cout, sum}, 32'h1ffff);
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        check("result", {15'd0, cout, sum}, {15'd0, e});
      end
    end
  end

  // Driver: issue one operation, then measure latency to out_valid.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                      input logic ts, input logic [W-1:0] es, input logic ec);
    int guard;
    int cnt;
    @(posedge clk); #1;
    a = ta; b = tb_v; cin = tc; sub = ts; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 100) check("accept_timeout", 0, 1);
    exp_q.push_back({ec, es});
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    cnt = 0;
    while (!out_valid && cnt < 50) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("latency", cnt, 4);
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    @(posedge clk); #1; rst = 1'b0;

    send(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0);
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
    send(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1);
    send(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1);
    send(16'hABCD, 16'h1234, 1'b0, 1'b0, 16'hBE01, 1'b0);
    send(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0);
    drain();

    // Back-pressure: result held, new request refused while DONE.
    out_ready = 1'b0;
    send(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0);
    a = 16'h0100; b = 16'h0200; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold_out_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_sum", sum, 16'h3333);
    end
    out_ready = 1'b1;
    exp_q.push_back({1'b0, 16'h0300});
    @(posedge clk); #1;
    check("idle_in_ready", in_ready, 1);
    check("idle_out_valid", out_valid, 0);
    @(posedge clk); #1;
    check("late_accept_busy", busy, 1);
    in_valid = 1'b0;
    drain();

    // Reset during the second RUN cycle discards the operation.
    @(posedge clk); #1;
    a = 16'hAAAA; b = 16'h5555; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_sum", sum, 0);
    check("mid_rst_cout", cout, 0);
    check("mid_rst_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_in_ready", in_ready, 1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("post_rst_no_valid", out_valid, 0);
    end
    send(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0);
    drain();

`ifdef CLA_SEQ_SUB_EN
    send(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0);
    send(16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1);
    drain();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
